// File: rtl/if_fetch_if.sv
// Instruction-bus channel between the fetch stage (master) and instruction memory (slave).
// Optional feature macro used by the fetch stage: IFETCH_MISALIGN_CHECK_EN.
interface if_fetch_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  // req/gnt: a request is accepted on an edge where req && gnt. After that, rvalid
  // strobes rdata for one cycle. At most one request is outstanding. addr may change while req && !gnt.
  modport master (output req, output addr, input gnt, input rvalid, input rdata);
  modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding reads, presents instr/addr or NOP.
// Optional macro IFETCH_MISALIGN_CHECK_EN: sticky misaligned-redirect flag that parks the fetch.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_,
  if_fetch_if.master  ibus,
  input  logic        stall_i,
  input  logic        jump_i,
  input  logic [31:0] jump_addr_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o,
`ifdef IFETCH_MISALIGN_CHECK_EN
  output logic        fetch_misaligned_o,
`endif
  output logic [2:0]  state_o
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_WAIT    = 3'd2,
    ST_PRESENT = 3'd3,
    ST_DRAIN   = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic [31:0] inst_addr_q;
  logic        inst_valid_q;
  logic [31:0] jump_target;
  logic        park_d;
  state_e      resume_st;

`ifdef IFETCH_MISALIGN_CHECK_EN
  logic park_q;

  assign jump_target = jump_addr_i;
  assign park_d      = jump_i ? (jump_addr_i[1:0] != 2'b00) : park_q;

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) park_q <= 1'b0;
    else      park_q <= park_d;
  end

  assign fetch_misaligned_o = park_q;
`else
  assign jump_target = jump_addr_i & ~32'h0000_0003;
  assign park_d      = 1'b0;
`endif

  // A parked fetch idles in IDLE instead of re-entering REQ.
  assign resume_st = park_d ? ST_IDLE : ST_REQ;

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (jump_i) begin
      unique case (state_q)
        ST_REQ:   state_d = ibus.gnt    ? ST_DRAIN  : resume_st;
        ST_WAIT:  state_d = ibus.rvalid ? resume_st : ST_DRAIN;
        ST_DRAIN: state_d = ibus.rvalid ? resume_st : ST_DRAIN;
        default:  state_d = resume_st;
      endcase
    end else begin
      unique case (state_q)
        ST_IDLE:    state_d = resume_st;
        ST_REQ:     if (ibus.gnt)    state_d = ST_WAIT;
        ST_WAIT:    if (ibus.rvalid) state_d = ST_PRESENT;
        ST_PRESENT: if (!stall_i)    state_d = resume_st;
        ST_DRAIN:   if (ibus.rvalid) state_d = resume_st;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    ibus.req  = (state_q == ST_REQ);
    ibus.addr = pc_q;
    state_o   = state_q;
  end

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      pc_q         <= RESET_PC;
      inst_q       <= NOP;
      inst_addr_q  <= 32'h0;
      inst_valid_q <= 1'b0;
    end else if (jump_i) begin
      pc_q         <= jump_target;
      inst_q       <= NOP;
      inst_addr_q  <= 32'h0;
      inst_valid_q <= 1'b0;
    end else if (state_q == ST_WAIT && ibus.rvalid) begin
      pc_q         <= pc_q + 32'd4;
      inst_q       <= ibus.rdata;
      inst_addr_q  <= pc_q;
      inst_valid_q <= 1'b1;
    end else if (state_q == ST_PRESENT && !stall_i) begin
      inst_q       <= NOP;
      inst_addr_q  <= 32'h0;
      inst_valid_q <= 1'b0;
    end
  end

  assign inst_o       = inst_q;
  assign inst_addr_o  = inst_addr_q;
  assign inst_valid_o = inst_valid_q;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: per-cycle vector table plus hand sequences for reset and misaligned redirect.
module tb_if_fetch;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_ = 1'b1;
  logic        stall_i = 1'b0;
  logic        jump_i = 1'b0;
  logic [31:0] jump_addr_i = 32'h0;
  logic [31:0] inst_o, inst_addr_o;
  logic        inst_valid_o;
  logic [2:0]  state_o;
`ifdef IFETCH_MISALIGN_CHECK_EN
  logic        mis_o;
`endif

  if_fetch_if ibus ();

  if_fetch #(.RESET_PC(32'h0000_0100)) dut (
    .clk          (clk),
    .rst_         (rst_),
    .ibus         (ibus.master),
    .stall_i      (stall_i),
    .jump_i       (jump_i),
    .jump_addr_i  (jump_addr_i),
    .inst_o       (inst_o),
    .inst_addr_o  (inst_addr_o),
    .inst_valid_o (inst_valid_o),
`ifdef IFETCH_MISALIGN_CHECK_EN
    .fetch_misaligned_o (mis_o),
`endif
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        jump;
    logic [31:0] jaddr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        stall;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_inst;
    logic [31:0] e_iaddr;
  } vec_t;

  vec_t vecs[40];
  int   n_vec = 0;
  int   tests = 0;
  int   failed = 0;

  task automatic add(input logic j, input logic [31:0] ja, input logic g, input logic rv,
                     input logic [31:0] rd, input logic st, input logic er, input logic [31:0] ea,
                     input logic ev, input logic [31:0] ei, input logic [31:0] eia);
    vecs[n_vec] = '{j, ja, g, rv, rd, st, er, ea, ev, ei, eia};
    n_vec++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic j, input logic [31:0] ja, input logic g, input logic rv,
                       input logic [31:0] rd, input logic st);
    jump_i = j; jump_addr_i = ja; ibus.gnt = g; ibus.rvalid = rv; ibus.rdata = rd; stall_i = st;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic er, input logic [31:0] ea, input logic ev,
                         input logic [31:0] ei, input logic [31:0] eia);
    chk({tag, ".req"},   {31'h0, ibus.req}, {31'h0, er});
    chk({tag, ".addr"},  ibus.addr, ea);
    chk({tag, ".valid"}, {31'h0, inst_valid_o}, {31'h0, ev});
    chk({tag, ".inst"},  inst_o, ei);
    chk({tag, ".iaddr"}, inst_addr_o, eia);
  endtask

  initial begin
    drive(0, 32'h0, 0, 0, 32'h0, 0);

    // Table: each row is the inputs before one edge and the outputs after it.
    add(0, 0,            0, 0, 0,            0, 1, 32'h100,      0, NOP,          0);
    add(0, 0,            1, 0, 0,            0, 0, 32'h100,      0, NOP,          0);
    add(0, 0,            0, 1, 32'hAAAA0001, 0, 0, 32'h104,      1, 32'hAAAA0001, 32'h100);
    add(0, 0,            0, 0, 0,            0, 1, 32'h104,      0, NOP,          0);
    add(0, 0,            1, 0, 0,            0, 0, 32'h104,      0, NOP,          0);
    add(0, 0,            0, 1, 32'hAAAA0002, 0, 0, 32'h108,      1, 32'hAAAA0002, 32'h104);
    add(0, 0,            0, 0, 0,            1, 0, 32'h108,      1, 32'hAAAA0002, 32'h104);
    add(0, 0,            1, 1, 32'h55555555, 1, 0, 32'h108,      1, 32'hAAAA0002, 32'h104);
    add(0, 0,            0, 0, 0,            1, 0, 32'h108,      1, 32'hAAAA0002, 32'h104);
    add(0, 0,            0, 0, 0,            1, 0, 32'h108,      1, 32'hAAAA0002, 32'h104);
    add(0, 0,            0, 0, 0,            0, 1, 32'h108,      0, NOP,          0);
    add(0, 0,            1, 0, 0,            0, 0, 32'h108,      0, NOP,          0);
    add(0, 0,            0, 1, 32'hAAAA0003, 0, 0, 32'h10C,      1, 32'hAAAA0003, 32'h108);
    add(0, 0,            0, 0, 0,            0, 1, 32'h10C,      0, NOP,          0);
    add(0, 0,            1, 0, 0,            0, 0, 32'h10C,      0, NOP,          0);
    add(1, 32'h200,      0, 0, 0,            0, 0, 32'h200,      0, NOP,          0);
    add(0, 0,            1, 0, 0,            0, 0, 32'h200,      0, NOP,          0);
    add(0, 0,            0, 1, 32'hDEADBEEF, 0, 1, 32'h200,      0, NOP,          0);
    add(1, 32'h300,      0, 0, 0,            0, 1, 32'h300,      0, NOP,          0);
    add(0, 0,            1, 0, 0,            0, 0, 32'h300,      0, NOP,          0);
    add(0, 0,            0, 1, 32'hBBBB0300, 0, 0, 32'h304,      1, 32'hBBBB0300, 32'h300);
    add(1, 32'hFFFFFFFC, 0, 0, 0,            1, 1, 32'hFFFFFFFC, 0, NOP,          0);
    add(0, 0,            1, 0, 0,            0, 0, 32'hFFFFFFFC, 0, NOP,          0);
    add(0, 0,            0, 1, 32'hCCCC0000, 0, 0, 32'h0,        1, 32'hCCCC0000, 32'hFFFFFFFC);
    add(0, 0,            0, 0, 0,            0, 1, 32'h0,        0, NOP,          0);
    add(1, 32'h400,      1, 0, 0,            0, 0, 32'h400,      0, NOP,          0);
    add(1, 32'h500,      0, 1, 32'h77777777, 0, 1, 32'h500,      0, NOP,          0);
    add(0, 0,            1, 0, 0,            0, 0, 32'h500,      0, NOP,          0);
    add(1, 32'h700,      0, 1, 32'h12345678, 0, 1, 32'h700,      0, NOP,          0);
`ifndef IFETCH_MISALIGN_CHECK_EN
    add(1, 32'h603,      0, 0, 0,            0, 1, 32'h600,      0, NOP,          0);
`endif

    // Reset state.
    @(posedge clk); #1;
    chk_out("reset", 0, 32'h100, 0, NOP, 0);
`ifdef IFETCH_MISALIGN_CHECK_EN
    chk("reset.mis", {31'h0, mis_o}, 32'h0);
`endif
    rst_ = 1'b0;

    for (int i = 0; i < n_vec; i++) begin
      drive(vecs[i].jump, vecs[i].jaddr, vecs[i].gnt, vecs[i].rvalid, vecs[i].rdata, vecs[i].stall);
      step();
      chk_out($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid,
              vecs[i].e_inst, vecs[i].e_iaddr);
    end
    drive(0, 0, 0, 0, 0, 0);

    // Reset asserted mid-transaction; a late response afterwards is ignored.
    rst_ = 1'b1;
    step();
    rst_ = 1'b0;
    drive(0, 0, 0, 1, 32'h99999999, 0);
    step();
    chk_out("rst_late", 1, 32'h100, 0, NOP, 0);
    drive(0, 0, 1, 0, 0, 0);
    step();
    chk_out("rst_gnt", 0, 32'h100, 0, NOP, 0);
    drive(0, 0, 0, 0, 0, 0);
    #2 rst_ = 1'b1;
    #1;
    chk_out("rst_async", 0, 32'h100, 0, NOP, 0);
    step();
    rst_ = 1'b0;
    drive(0, 0, 0, 1, 32'h88888888, 0);
    step();
    chk_out("rst_stale", 1, 32'h100, 0, NOP, 0);
    drive(0, 0, 1, 0, 0, 0);
    step();
    drive(0, 0, 0, 1, 32'h11110100, 0);
    step();
    chk_out("rst_fetch", 0, 32'h104, 1, 32'h11110100, 32'h100);

`ifdef IFETCH_MISALIGN_CHECK_EN
    // Misaligned redirect parks the fetch until an aligned redirect.
    drive(1, 32'h402, 0, 0, 0, 0);
    step();
    chk_out("mis_set", 0, 32'h402, 0, NOP, 0);
    chk("mis_set.flag", {31'h0, mis_o}, 32'h1);
    drive(0, 0, 1, 1, 32'h33333333, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("mis_park%0d.req", i), {31'h0, ibus.req}, 32'h0);
      chk($sformatf("mis_park%0d.flag", i), {31'h0, mis_o}, 32'h1);
    end
    drive(1, 32'h500, 0, 0, 0, 0);
    step();
    chk_out("mis_clr", 1, 32'h500, 0, NOP, 0);
    chk("mis_clr.flag", {31'h0, mis_o}, 32'h0);
    drive(0, 0, 0, 0, 0, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
